// File: rtl/i2c_dpi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_dpi_pkg
// Description : Shared types and constants for the i2c_dpi target model.
//               The state enum and the ACK/NAK bit levels are used by the top.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_dpi_pkg;

    // Target protocol states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        WAIT     = 3'd7
    } i2c_tgt_state_e;

    // Open-drain level for the acknowledge slot
    localparam logic       AckBit      = 1'b0;
    localparam logic       NakBit      = 1'b1;
    localparam logic [3:0] BitsPerByte = 4'd8;

endpackage
`default_nettype wire

// File: rtl/i2c_dpi_cond_det.sv
`default_nettype none
// ============================================================================
// Module      : i2c_dpi_cond_det
// Description : Two-flop synchronisers for SCL/SDA plus single-cycle pulses
//               for SCL rise/fall and START/STOP bus conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_dpi_cond_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_sync_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_s;
    logic       sda_s;

    // Shift the raw bus into the synchronisers and keep the previous synced value
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Synchroniser and history flops; idle bus level is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    assign sda_sync_o = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SDA may only move while SCL stays high for a START/STOP
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_dpi.sv
`default_nettype none
// ============================================================================
// Module      : i2c_dpi
// Description : I2C target with an EEPROM-style register pointer and an
//               out-of-band presence/busy side channel. Optional clock
//               stretching after each ACK slot is enabled by defining
//               I2C_DPI_CLK_STRETCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_dpi
    import i2c_dpi_pkg::*;
#(
    parameter string      ID         = "i2c0",
    parameter logic [6:0] TargetAddr = 7'h50,
    parameter int         NumRegs    = 16,
    parameter int         StretchCyc = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    input  logic oob_in,
    output logic oob_out
);

    localparam int PtrW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_dpi_cond_det u_cond_det (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_sync_o (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    i2c_tgt_state_e  state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_q, rx_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [7:0]      regs_q [NumRegs];
    logic [7:0]      regs_d [NumRegs];
    logic            sda_q, sda_d;
    logic            oob_q, oob_d;
    logic            first_q, first_d;
    logic            rw_q, rw_d;
    logic            host_nak_q, host_nak_d;
    logic [7:0]      rd_byte;
    logic [2:0]      rd_bit_idx;

    // The pointer only moves in the ACK slot, so the byte being read is stable
    assign rd_byte    = regs_q[ptr_q];
    assign rd_bit_idx = 3'(4'd7 - bit_cnt_q);

    // Protocol FSM: bus conditions first, then per-state bit/byte handling
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        sda_d      = sda_q;
        oob_d      = oob_q;
        first_d    = first_q;
        rw_d       = rw_q;
        host_nak_d = host_nak_q;

        if (stop) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
            oob_d     = 1'b0;
        end else if (start) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        rx_d      = {rx_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
                        bit_cnt_d = '0;
                        if (rx_q[7:1] == TargetAddr && !oob_in) begin
                            sda_d   = AckBit;
                            oob_d   = 1'b1;
                            rw_d    = rx_q[0];
                            state_d = ADDR_ACK;
                        end else begin
                            sda_d   = NakBit;
                            oob_d   = 1'b0;
                            state_d = WAIT;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            sda_d   = rd_byte[7];
                            state_d = RD_DATA;
                        end else begin
                            sda_d   = 1'b1;
                            first_d = 1'b1;
                            state_d = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        rx_d      = {rx_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
                        bit_cnt_d = '0;
                        sda_d     = AckBit;
                        state_d   = WR_ACK;
                        if (first_q) begin
                            ptr_d   = rx_q[PtrW-1:0];
                            first_d = 1'b0;
                        end else begin
                            regs_d[ptr_q] = rx_q;
                            ptr_d         = ptr_q + 1'b1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_d   = 1'b1;
                        state_d = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
                        bit_cnt_d = '0;
                        sda_d     = 1'b1;
                        state_d   = RD_ACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        sda_d = rd_byte[rd_bit_idx];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        host_nak_d = sda_s;
                        ptr_d      = ptr_q + 1'b1;
                        bit_cnt_d  = 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        if (host_nak_q == NakBit) begin
                            sda_d   = 1'b1;
                            state_d = WAIT;
                        end else begin
                            sda_d   = rd_byte[7];
                            state_d = RD_DATA;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, datapath and register bank; reset releases the bus immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            ptr_q      <= '0;
            sda_q      <= 1'b1;
            oob_q      <= 1'b0;
            first_q    <= 1'b0;
            rw_q       <= 1'b0;
            host_nak_q <= 1'b0;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            ptr_q      <= ptr_d;
            sda_q      <= sda_d;
            oob_q      <= oob_d;
            first_q    <= first_d;
            rw_q       <= rw_d;
            host_nak_q <= host_nak_d;
            regs_q     <= regs_d;
        end
    end

    assign sda_o   = sda_q;
    assign oob_out = oob_q;

`ifdef I2C_DPI_CLK_STRETCH_EN
    localparam int StretchW = $clog2(StretchCyc + 1);

    logic [StretchW-1:0] stretch_cnt_q, stretch_cnt_d;
    logic                stretch_go;

    // Falling edge that closes an ACK/NAK slot starts a stretch
    assign stretch_go = scl_fall & ~start & ~stop &
                        ((state_q == ADDR_ACK) || (state_q == WR_ACK) ||
                         (state_q == RD_ACK && bit_cnt_q == 4'd1));

    // Load the hold time on a slot close, then count it down to release
    always_comb begin
        stretch_cnt_d = stretch_cnt_q;
        if (stretch_go) begin
            stretch_cnt_d = StretchW'(StretchCyc);
        end else if (stretch_cnt_q != '0) begin
            stretch_cnt_d = stretch_cnt_q - 1'b1;
        end
    end

    // Stretch counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stretch_cnt_q <= '0;
        end else begin
            stretch_cnt_q <= stretch_cnt_d;
        end
    end

    assign scl_o = (stretch_cnt_q == '0);
`else
    assign scl_o = 1'b1;
`endif

`ifndef SYNTHESIS
    int sim_bytes_q;

    // Report each finished transaction that was addressed to this target
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sim_bytes_q <= 0;
        end else if ((start || stop) && oob_q) begin
            $display("%s: addr=0x%02h %s bytes=%0d", ID, TargetAddr,
                     rw_q ? "R" : "W", sim_bytes_q);
            sim_bytes_q <= 0;
        end else if (scl_fall && bit_cnt_q == BitsPerByte &&
                     (state_q == WR_DATA || state_q == RD_DATA)) begin
            sim_bytes_q <= sim_bytes_q + 1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_dpi.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_dpi
// Description : Directed self-checking bench for i2c_dpi. A bit-level host
//               model drives the open-drain bus; each scenario task checks
//               its own results against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_dpi;
    import i2c_dpi_pkg::*;

    localparam int Q = 8;   // quarter SCL period in clk cycles

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic host_scl = 1'b1;
    logic host_sda = 1'b1;
    logic oob_in   = 1'b0;
    logic scl_o;
    logic sda_o;
    logic oob_out;
    logic scl_bus;
    logic sda_bus;

    int checks   = 0;
    int failures = 0;

    assign scl_bus = host_scl & scl_o;
    assign sda_bus = host_sda & sda_o;

    always #5 clk = ~clk;

    i2c_dpi #(
        .ID         ("i2c0"),
        .TargetAddr (7'h50),
        .NumRegs    (16),
        .StretchCyc (8)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .scl_i   (scl_bus),
        .sda_i   (sda_bus),
        .scl_o   (scl_o),
        .sda_o   (sda_o),
        .oob_in  (oob_in),
        .oob_out (oob_out)
    );

`ifdef I2C_DPI_CLK_STRETCH_EN
    int low_run = 0;
    int run_lens[$];

    // Record the length of every interval in which the target holds SCL low
    always @(posedge clk) begin
        if (scl_o === 1'b0) begin
            low_run <= low_run + 1;
        end else if (low_run != 0) begin
            run_lens.push_back(low_run);
            low_run <= 0;
        end
    end
`endif

    // ---------------- host bus model ----------------
    task automatic wait_scl_high();
        int n = 0;
        while (scl_bus !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (scl_bus !== 1'b1) begin
            failures++;
            $display("FAIL scl_release_timeout: scl=%b expected 1", scl_bus);
        end
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        repeat (Q) @(negedge clk);
        host_sda = b;
        repeat (Q) @(negedge clk);
        host_scl = 1'b1;
        wait_scl_high();
        repeat (Q) @(negedge clk);
        s = sda_bus;
        repeat (Q) @(negedge clk);
        host_scl = 1'b0;
    endtask

    task automatic do_start();
        repeat (Q) @(negedge clk);
        host_sda = 1'b1;
        repeat (Q) @(negedge clk);
        host_scl = 1'b1;
        wait_scl_high();
        repeat (Q) @(negedge clk);
        host_sda = 1'b0;
        repeat (Q) @(negedge clk);
        host_scl = 1'b0;
    endtask

    task automatic do_stop();
        repeat (Q) @(negedge clk);
        host_sda = 1'b0;
        repeat (Q) @(negedge clk);
        host_scl = 1'b1;
        wait_scl_high();
        repeat (Q) @(negedge clk);
        host_sda = 1'b1;
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(d[i], s);
        end
        bit_cycle(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, s);
            d = {d[6:0], s};
        end
        bit_cycle(ack, s);
    endtask

    // Set the pointer and read a single byte back (NAKed)
    task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
        logic ack;
        do_start();
        send_byte(8'hA0, ack);
        send_byte(a, ack);
        do_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b1, d);
        do_stop();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (scl_o !== 1'b1) begin failures++; $display("FAIL reset_scl_o: got %b expected 1", scl_o); end
        checks++;
        if (sda_o !== 1'b1) begin failures++; $display("FAIL reset_sda_o: got %b expected 1", sda_o); end
        checks++;
        if (oob_out !== 1'b0) begin failures++; $display("FAIL reset_oob_out: got %b expected 0", oob_out); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_write();
        logic       ack;
        logic [7:0] seq [3];
        seq = '{8'h03, 8'hAA, 8'hBB};
        do_start();
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL write_addr_ack: got %b expected 0", ack); end
        checks++;
        if (oob_out !== 1'b1) begin failures++; $display("FAIL write_oob_busy: got %b expected 1", oob_out); end
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i], ack);
            checks++;
            if (ack !== 1'b0) begin failures++; $display("FAIL write_data_ack[%0d]: got %b expected 0", i, ack); end
        end
        checks++;
        if (oob_out !== 1'b1) begin failures++; $display("FAIL write_oob_before_stop: got %b expected 1", oob_out); end
        do_stop();
        repeat (4) @(negedge clk);
        checks++;
        if (oob_out !== 1'b0) begin failures++; $display("FAIL write_oob_after_stop: got %b expected 0", oob_out); end
        checks++;
        if (dut.state_q !== IDLE) begin failures++; $display("FAIL write_state_idle: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        do_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL read_ptr_ack: got %b expected 0", ack); end
        do_start();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL read_addr_ack: got %b expected 0", ack); end
        recv_byte(1'b0, d);
        checks++;
        if (d !== 8'hAA) begin failures++; $display("FAIL read_byte0: got %h expected aa", d); end
        recv_byte(1'b1, d);
        checks++;
        if (d !== 8'hBB) begin failures++; $display("FAIL read_byte1: got %h expected bb", d); end
        repeat (Q) @(negedge clk);
        checks++;
        if (sda_o !== 1'b1) begin failures++; $display("FAIL read_release_after_nak: got %b expected 1", sda_o); end
        checks++;
        if (dut.state_q !== WAIT) begin failures++; $display("FAIL read_state_wait: got %0d expected %0d", dut.state_q, WAIT); end
        do_stop();
    endtask

    task automatic test_nak_addr();
        logic       ack;
        logic [7:0] d;
        do_start();
        send_byte(8'hA2, ack);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL nak_addr_ack: got %b expected 1", ack); end
        checks++;
        if (oob_out !== 1'b0) begin failures++; $display("FAIL nak_addr_oob: got %b expected 0", oob_out); end
        send_byte(8'h03, ack);
        send_byte(8'h77, ack);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL nak_addr_data_ack: got %b expected 1", ack); end
        do_stop();
        read_reg(8'h03, d);
        checks++;
        if (d !== 8'hAA) begin failures++; $display("FAIL nak_addr_regs_kept: got %h expected aa", d); end
    endtask

    task automatic test_oob_absent();
        logic ack;
        oob_in = 1'b1;
        do_start();
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL oob_absent_ack: got %b expected 1", ack); end
        checks++;
        if (oob_out !== 1'b0) begin failures++; $display("FAIL oob_absent_busy: got %b expected 0", oob_out); end
        do_stop();
        oob_in = 1'b0;
    endtask

    task automatic test_wrap();
        logic       ack;
        logic [7:0] d;
        logic [7:0] seq [4];
        seq = '{8'hA0, 8'h0F, 8'h11, 8'h22};
        do_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], ack);
            checks++;
            if (ack !== 1'b0) begin failures++; $display("FAIL wrap_write_ack[%0d]: got %b expected 0", i, ack); end
        end
        do_stop();
        do_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        do_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b0, d);
        checks++;
        if (d !== 8'h11) begin failures++; $display("FAIL wrap_reg15: got %h expected 11", d); end
        recv_byte(1'b1, d);
        checks++;
        if (d !== 8'h22) begin failures++; $display("FAIL wrap_reg0: got %h expected 22", d); end
        do_stop();
    endtask

    task automatic test_abort();
        logic       ack;
        logic       s;
        logic [7:0] d;
        do_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        bit_cycle(1'b0, s);
        bit_cycle(1'b1, s);
        bit_cycle(1'b0, s);
        bit_cycle(1'b1, s);
        do_stop();
        repeat (4) @(negedge clk);
        checks++;
        if (dut.state_q !== IDLE) begin failures++; $display("FAIL abort_state_idle: got %0d expected %0d", dut.state_q, IDLE); end
        read_reg(8'h03, d);
        checks++;
        if (d !== 8'hAA) begin failures++; $display("FAIL abort_no_write: got %h expected aa", d); end
    endtask

    task automatic test_reset_mid_read();
        logic       ack;
        logic       s;
        logic [7:0] d;
        do_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        do_start();
        send_byte(8'hA1, ack);
        bit_cycle(1'b1, s);
        checks++;
        if (s !== 1'b1) begin failures++; $display("FAIL midread_bit7: got %b expected 1", s); end
        repeat (Q) @(negedge clk);
        checks++;
        if (sda_o !== 1'b0) begin failures++; $display("FAIL midread_bit6_driven: got %b expected 0", sda_o); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sda_o !== 1'b1) begin failures++; $display("FAIL midread_reset_sda: got %b expected 1", sda_o); end
        checks++;
        if (scl_o !== 1'b1) begin failures++; $display("FAIL midread_reset_scl: got %b expected 1", scl_o); end
        checks++;
        if (oob_out !== 1'b0) begin failures++; $display("FAIL midread_reset_oob: got %b expected 0", oob_out); end
        repeat (2) @(negedge clk);
        host_scl = 1'b1;
        repeat (2) @(negedge clk);
        host_sda = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        read_reg(8'h03, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL midread_regs_cleared: got %h expected 00", d); end
    endtask

`ifdef I2C_DPI_CLK_STRETCH_EN
    task automatic test_stretch();
        checks++;
        if (run_lens.size() == 0) begin failures++; $display("FAIL stretch_seen: got 0 stretches expected >0"); end
        foreach (run_lens[i]) begin
            checks++;
            if (run_lens[i] != 8) begin failures++; $display("FAIL stretch_len[%0d]: got %0d expected 8", i, run_lens[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nak_addr();
        test_oob_absent();
        test_wrap();
        test_abort();
        test_reset_mid_read();
`ifdef I2C_DPI_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
